// File: rtl/alu_pipe.sv
// Single-stage pipelined ALU with a valid/ready handshake on both sides.
// The result, its opcode and the N/Z/V flags are registered one cycle after accept.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_opcode,
  output logic             n_flag,
  output logic             z_flag,
  output logic             v_flag
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3,
    OP_SLL    = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7,
    OP_LW     = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB,
    OP_B      = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF
  } op_e;

  localparam int NLANE = WIDTH / LANE;
  localparam int NBYTE = WIDTH / 8;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LMIN = {1'b1, {(LANE-1){1'b0}}};

  op_e              w_op;
  logic             w_accept;
  logic [WIDTH:0]   w_addsub;
  logic             w_ovf;
  logic [WIDTH-1:0] w_sat;
  logic [WIDTH-1:0] w_red;
  logic [WIDTH-1:0] w_padd;
  logic [LANE-1:0]  w_la;
  logic [LANE-1:0]  w_lb;
  logic [LANE:0]    w_lsum;
  logic [7:0]       w_ba;
  logic [7:0]       w_bb;
  logic [SHW-1:0]   w_sh;
  logic [SHW-1:0]   w_shc;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_res;
  logic             w_wn;
  logic             w_wz;
  logic             w_wv;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [3:0]       r_opcode;
  logic             r_n;
  logic             r_z;
  logic             r_v;

  assign w_op     = op_e'(opcode);
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // One extra sign bit exposes signed overflow as a mismatch of the top two bits.
  assign w_addsub = (w_op == OP_SUB) ? ({in_a[WIDTH-1], in_a} - {in_b[WIDTH-1], in_b})
                                     : ({in_a[WIDTH-1], in_a} + {in_b[WIDTH-1], in_b});
  assign w_ovf    = w_addsub[WIDTH] ^ w_addsub[WIDTH-1];
  assign w_sat    = w_ovf ? (w_addsub[WIDTH] ? SMIN : SMAX) : w_addsub[WIDTH-1:0];

  assign w_sh  = in_b[SHW-1:0];
  assign w_shc = -w_sh;
  assign w_sra = $signed(in_a) >>> w_sh;

  always_comb begin
    w_red = '0;
    w_ba  = '0;
    w_bb  = '0;
    for (int unsigned i = 0; i < NBYTE; i++) begin
      w_ba  = in_a[8*i +: 8];
      w_bb  = in_b[8*i +: 8];
      w_red = w_red + {{(WIDTH-8){w_ba[7]}}, w_ba} + {{(WIDTH-8){w_bb[7]}}, w_bb};
    end
  end

  always_comb begin
    w_padd = '0;
    w_la   = '0;
    w_lb   = '0;
    w_lsum = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      w_la   = in_a[LANE*i +: LANE];
      w_lb   = in_b[LANE*i +: LANE];
      w_lsum = {w_la[LANE-1], w_la} + {w_lb[LANE-1], w_lb};
      if (w_lsum[LANE] != w_lsum[LANE-1])
        w_padd[LANE*i +: LANE] = w_lsum[LANE] ? LMIN : LMAX;
      else
        w_padd[LANE*i +: LANE] = w_lsum[LANE-1:0];
    end
  end

  always_comb begin
    w_res = in_a;
    w_wn  = 1'b0;
    w_wz  = 1'b0;
    w_wv  = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_res = w_sat;
        w_wn  = 1'b1;
        w_wz  = 1'b1;
        w_wv  = 1'b1;
      end
      OP_XOR:    begin w_res = in_a ^ in_b;                       w_wz = 1'b1; end
      OP_RED:    w_res = w_red;
      OP_SLL:    begin w_res = in_a << w_sh;                      w_wz = 1'b1; end
      OP_SRA:    begin w_res = w_sra;                             w_wz = 1'b1; end
      OP_ROR:    begin w_res = (in_a >> w_sh) | (in_a << w_shc);  w_wz = 1'b1; end
      OP_PADDSB: w_res = w_padd;
      OP_LW, OP_SW: w_res = in_a + in_b;
      OP_LLB:    w_res[7:0]  = in_b[7:0];
      OP_LHB:    w_res[15:8] = in_b[7:0];
      OP_B, OP_BR, OP_PCS, OP_HLT: w_res = in_a;
      default:   w_res = in_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_opcode <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_data   <= w_res;
      r_opcode <= opcode;
      if (w_wn) r_n <= w_res[WIDTH-1];
      if (w_wz) r_z <= (w_res == '0);
      if (w_wv) r_v <= w_ovf;
    end else if (out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign out_opcode = r_opcode;
  assign n_flag     = r_n;
  assign z_flag     = r_z;
  assign v_flag     = r_v;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: vector table through a scoreboard, plus backpressure,
// mid-stream reset and a 32-bit instance.
module tb_alu_pipe;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        n;
    logic        z;
    logic        v;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_opcode;
  logic        n_flag;
  logic        z_flag;
  logic        v_flag;

  logic        in_valid32;
  logic        in_ready32;
  logic [3:0]  opcode32;
  logic [31:0] in_a32;
  logic [31:0] in_b32;
  logic        out_valid32;
  logic [31:0] out_data32;
  logic [3:0]  out_opcode32;
  logic        n32;
  logic        z32;
  logic        v32;

  int total = 0;
  int bad   = 0;

  logic [22:0] cur_exp;
  logic [22:0] sbq[$];
  vec_t        tbl[$];

  alu_pipe #(.WIDTH(16), .LANE(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_opcode(out_opcode), .n_flag(n_flag), .z_flag(z_flag), .v_flag(v_flag)
  );

  alu_pipe #(.WIDTH(32), .LANE(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .opcode(opcode32), .in_a(in_a32), .in_b(in_b32),
    .out_valid(out_valid32), .out_ready(1'b1), .out_data(out_data32),
    .out_opcode(out_opcode32), .n_flag(n32), .z_flag(z32), .v_flag(v32)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] d, input logic n, input logic z, input logic v);
    in_valid = 1'b1;
    opcode   = op;
    in_a     = a;
    in_b     = b;
    cur_exp  = {op, d, n, z, v};
  endtask

  // Results are checked at the negedge before the edge that consumes them.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", {out_opcode, out_data, n_flag, z_flag, v_flag}, 64'h0);
        end else begin
          chk("sb_result", {out_opcode, out_data, n_flag, z_flag, v_flag}, sbq.pop_front());
        end
      end
      if (in_valid && in_ready) sbq.push_back(cur_exp);
    end
  end

  initial begin
    tbl.push_back('{4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'h0, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{4'h2, 16'h00F0, 16'h00F0, 16'h0000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{4'hA, 16'h1234, 16'h00AB, 16'h12AB, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{4'h7, 16'h7781, 16'h1188, 16'h7789, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{4'h3, 16'h0102, 16'h03FF, 16'h0005, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{4'h6, 16'h8001, 16'h0001, 16'hC000, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{4'h5, 16'h8000, 16'h000F, 16'hFFFF, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{4'h4, 16'h0001, 16'h0010, 16'h0001, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{4'h1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{4'h1, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{4'h0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h4, 16'h00FF, 16'h0004, 16'h0FF0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h4, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'h8, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'h9, 16'h1000, 16'h0234, 16'h1234, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'hB, 16'h1234, 16'h12AB, 16'hAB34, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'hC, 16'hBEEF, 16'h1234, 16'hBEEF, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'hD, 16'h0F0F, 16'h0000, 16'h0F0F, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'hE, 16'h0042, 16'hFFFF, 16'h0042, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'h2, 16'h5555, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h6, 16'h1234, 16'h0004, 16'h4123, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h5, 16'h4000, 16'h0003, 16'h0800, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h5, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h3, 16'h8080, 16'h8080, 16'hFE00, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h7, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h1, 16'h0000, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'hF, 16'hABCD, 16'h0000, 16'hABCD, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'h6, 16'h8001, 16'h0020, 16'h8001, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{4'h7, 16'h8888, 16'h8888, 16'h8888, 1'b0, 1'b0, 1'b0});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; in_a = '0; in_b = '0; cur_exp = '0;
    in_valid32 = 1'b0; opcode32 = '0; in_a32 = '0; in_b32 = '0;
    step(); step();
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_opcode", out_opcode, 0);
    chk("rst_flags", {n_flag, z_flag, v_flag}, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Back-to-back table stream with the consumer always ready.
    step();
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].n, tbl[i].z, tbl[i].v);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && sbq.size() != 0; k++) step();
    step();
    chk("tbl_drain", sbq.size(), 0);

    // Backpressure: consumer stalls for two cycles after the first result.
    drive(4'h0, 16'h0100, 16'h0200, 16'h0300, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'h1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {out_valid, out_opcode, out_data, n_flag, z_flag, v_flag},
          {1'b1, 4'h0, 16'h0300, 3'b000});
      step();
    end
    out_ready = 1'b1;
    step();
    drive(4'h2, 16'h00FF, 16'h00FF, 16'h0000, 1'b1, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("bp_valid_clear", out_valid, 0);
    chk("bp_drain", sbq.size(), 0);

    // Reset while a result is pending and another op is presented.
    step();
    drive(4'h0, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1);
    step();
    drive(4'h0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_pre", {out_valid, out_data, n_flag, z_flag, v_flag}, {1'b1, 16'h8000, 3'b101});
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mr_cleared", {out_valid, out_opcode, out_data, n_flag, z_flag, v_flag}, 0);
    chk("mr_in_ready", in_ready, 1);
    step();
    @(negedge clk);
    chk("mr_not_accepted", out_valid, 0);

    // 32-bit instance, pipelined stream.
    step();
    in_valid32 = 1'b1; opcode32 = 4'h0; in_a32 = 32'h7FFF_FFFF; in_b32 = 32'h0000_0001;
    step();
    opcode32 = 4'hB; in_a32 = 32'hDEAD_1234; in_b32 = 32'h0000_00AB;
    @(negedge clk);
    chk("w32_add_sat", {out_valid32, out_data32, n32, z32, v32}, {1'b1, 32'h7FFF_FFFF, 3'b001});
    step();
    opcode32 = 4'h3; in_a32 = 32'h0102_0304; in_b32 = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("w32_lhb", {out_valid32, out_data32, n32, z32, v32}, {1'b1, 32'hDEAD_AB34, 3'b001});
    step();
    opcode32 = 4'h1; in_a32 = 32'h8000_0000; in_b32 = 32'h0000_0001;
    @(negedge clk);
    chk("w32_red", {out_valid32, out_data32, n32, z32, v32}, {1'b1, 32'h0000_0006, 3'b001});
    step();
    in_valid32 = 1'b0;
    @(negedge clk);
    chk("w32_sub_sat", {out_valid32, out_opcode32, out_data32, n32, z32, v32},
        {1'b1, 4'h1, 32'h8000_0000, 3'b101});
    chk("w32_in_ready", in_ready32, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
